// File: rtl/ram2_pkg.sv
// ram2 controller shared types and defaults.
// Holds bus widths, FSM state encoding and the clear word count.
package ram2_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int CLR_WORDS = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RCAP,
        ST_TURN,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/ram2_ctrl_if.sv
// Request/response handshake bundle for ram2_ctrl.
// master issues requests; slave is the controller.
interface ram2_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/ram2_bus_drv.sv
// Tri-state driver for the shared ram2 data bus.
// Drives dout onto the bus when oe is set; always samples it on din.
module ram2_bus_drv #(
    parameter int DATA_W = 32
) (
    input  logic              i_oe,
    input  logic [DATA_W-1:0] i_dout,
    output logic [DATA_W-1:0] o_din,
    inout  wire  [DATA_W-1:0] io_bus
);
    assign io_bus = i_oe ? i_dout : {DATA_W{1'bz}};
    assign o_din  = io_bus;
endmodule

// File: rtl/ram2_ctrl.sv
// Single-outstanding request controller for a ram2 bidirectional-bus RAM.
// Optional RAM2_CTRL_CLEAR_EN: zero all words after reset release.
module ram2_ctrl
    import ram2_pkg::*;
#(
    parameter int ADDR_W = ram2_pkg::ADDR_W,
    parameter int DATA_W = ram2_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    ram2_ctrl_if.slave        bus,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

`ifdef RAM2_CTRL_CLEAR_EN
    localparam state_t RST_ST = ST_CLEAR;
`else
    localparam state_t RST_ST = ST_IDLE;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rsp_valid;
    logic                w_accept;
    logic                w_ena;
    logic                w_wena;
    logic                w_oe;
    logic [DATA_W-1:0]   w_dout;
    logic [DATA_W-1:0]   w_din;
    logic                w_clr_last;

    assign bus.req_ready = rst_n && (r_state == ST_IDLE);
    assign bus.busy      = rst_n && (r_state != ST_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;

    assign w_accept   = bus.req_valid && bus.req_ready;
    assign w_clr_last = (r_addr == ADDR_W'(CLR_WORDS - 1));

    assign ram_ena  = w_ena;
    assign ram_wena = w_wena;
    assign ram_addr = r_addr;
    assign w_dout   = (r_state == ST_CLEAR) ? '0 : r_wdata;

    ram2_bus_drv #(
        .DATA_W (DATA_W)
    ) u_drv (
        .i_oe   (w_oe),
        .i_dout (w_dout),
        .o_din  (w_din),
        .io_bus (ram_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RST_ST;
        else        r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_next = bus.req_we ? ST_WRITE : ST_READ;
            end
            ST_WRITE: w_next = ST_IDLE;
            ST_READ:  w_next = ST_RCAP;
            ST_RCAP:  w_next = ST_TURN;
            ST_TURN:  w_next = ST_IDLE;
            ST_CLEAR: begin
                if (w_clr_last) w_next = ST_IDLE;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // RAM strobes and bus enable; all quiet while in reset
    always_comb begin
        w_ena  = 1'b0;
        w_wena = 1'b0;
        w_oe   = 1'b0;
        unique case (r_state)
            ST_WRITE, ST_CLEAR: begin
                w_ena  = 1'b1;
                w_wena = 1'b1;
                w_oe   = 1'b1;
            end
            ST_READ, ST_RCAP: w_ena = 1'b1;
            default: ;
        endcase
        if (!rst_n) begin
            w_ena  = 1'b0;
            w_wena = 1'b0;
            w_oe   = 1'b0;
        end
    end

    // Request capture; address doubles as the clear counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end else if (r_state == ST_CLEAR) begin
            r_addr  <= r_addr + ADDR_W'(1);
        end
    end

    // Read capture at the end of RCAP and one-cycle response pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rsp_valid <= (r_state == ST_RCAP);
            if (r_state == ST_RCAP)
                r_rdata <= w_din;
        end
    end

endmodule

// File: tb/tb_ram2_ctrl.sv
// Directed self-checking bench for ram2_ctrl with a behavioural ram2.
// Covers writes, reads, back-to-back traffic, mid-read reset and clear.
module tb_ram2_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_ena;
    logic        ram_wena;
    logic [4:0]  ram_addr;
    wire  [31:0] ram_data;
    logic [31:0] mem [32];

    int total = 0;
    int bad   = 0;

    ram2_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    ram2_ctrl #(
        .ADDR_W (5),
        .DATA_W (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .ram_ena  (ram_ena),
        .ram_wena (ram_wena),
        .ram_addr (ram_addr),
        .ram_data (ram_data)
    );

    always #5 clk = ~clk;

    // Behavioural ram2: write on edge, asynchronous read drive
    always @(posedge clk) begin
        if (ram_ena && ram_wena)
            mem[ram_addr] <= ram_data;
    end
    assign ram_data = (ram_ena && !ram_wena) ? mem[ram_addr] : 32'hzzzzzzzz;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        #1;
        check("wr_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'h0;
        #1;
        check("wr_ena", {30'd0, ram_ena, ram_wena}, 32'd3);
        check("wr_addr", {27'd0, ram_addr}, {27'd0, a});
        check("wr_bus", ram_data, d);
        check("wr_busy", {30'd0, bus.busy, bus.req_ready}, 32'd2);
        @(negedge clk);
        #1;
        check("wr_ready_back", {31'd0, bus.req_ready}, 32'd1);
        check("wr_mem", mem[a], d);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [31:0] exp);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        #1;
        check("rd_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 5'd0;
        #1;
        check("rd_read_ena", {30'd0, ram_ena, ram_wena}, 32'd2);
        check("rd_read_bus", ram_data, exp);
        check("rd_read_vld", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("rd_rcap_ena", {30'd0, ram_ena, ram_wena}, 32'd2);
        check("rd_rcap_addr", {27'd0, ram_addr}, {27'd0, a});
        check("rd_rcap_bus", ram_data, exp);
        check("rd_rcap_vld", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("rd_turn_vld", {31'd0, bus.rsp_valid}, 32'd1);
        check("rd_turn_data", bus.rsp_rdata, exp);
        check("rd_turn_ena", {31'd0, ram_ena}, 32'd0);
        check("rd_turn_bus", ram_data, 32'hzzzzzzzz);
        @(negedge clk);
        #1;
        check("rd_vld_drop", {31'd0, bus.rsp_valid}, 32'd0);
        check("rd_held", bus.rsp_rdata, exp);
        check("rd_ready_back", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic do_reset();
        int n;
        rst_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_vld", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_ena", {30'd0, ram_ena, ram_wena}, 32'd0);
        check("rst_addr", {27'd0, ram_addr}, 32'd0);
        check("rst_bus", ram_data, 32'hzzzzzzzz);
        @(negedge clk);
        #1;
        check("rst_vld_hold", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.req_ready) break;
            if (bus.busy) n++;
            check("rst_no_vld", {31'd0, bus.rsp_valid}, 32'd0);
            @(negedge clk);
            #1;
        end
        check("rst_ready_up", {31'd0, bus.req_ready}, 32'd1);
`ifdef RAM2_CTRL_CLEAR_EN
        check("clr_busy_cnt", n, 32'd32);
`else
        check("clr_busy_cnt", n, 32'd0);
`endif
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 5'd0;
        bus.req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        do_reset();

        do_write(5'h0A, 32'habcdef12);
        do_write(5'h15, 32'h12345678);
        check("mem10", mem[10], 32'habcdef12);

        do_read(5'h0A, 32'habcdef12);
        do_read(5'h15, 32'h12345678);

        do_write(5'h1F, 32'hFFFFFFFF);
        do_read(5'h1F, 32'hFFFFFFFF);
        do_write(5'h00, 32'h00000001);
        check("mem31", mem[31], 32'hFFFFFFFF);
        check("mem0", mem[0], 32'h00000001);

        // Reset while the read of 0x0A sits in RCAP
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 5'h0A;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rcap_ena", {30'd0, ram_ena, ram_wena}, 32'd2);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("mid_no_vld", {31'd0, bus.rsp_valid}, 32'd0);
        end
        check("mid_mem", mem[10], 32'habcdef12);

        // Preload, reset, read back: cleared only with the clear option
        do_write(5'h07, 32'h5A5A5A5A);
        do_reset();
`ifdef RAM2_CTRL_CLEAR_EN
        do_read(5'h07, 32'h00000000);
`else
        do_read(5'h07, 32'h5A5A5A5A);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram2_ctrl.md
RAM2_CTRL -- requirements
Module: ram2_ctrl

Interface
REQ-001 Parameter: ADDR_W, 5, RAM word-address width (32 words).
REQ-002 Parameter: DATA_W, 32, RAM word width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  upstream request present.
REQ-006 req_ready  out  1  controller accepts request this cycle.
REQ-007 req_we  in  1  1=write, 0=read.
REQ-008 req_addr  in  ADDR_W  target word address.
REQ-009 req_wdata  in  DATA_W  write data.
REQ-010 rsp_valid  out  1  one-cycle pulse; rsp_rdata valid.
REQ-011 rsp_rdata  out  DATA_W  read result, held until next read completes.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 ram_ena  out  1  drives ram2 ena.
REQ-014 ram_wena  out  1  drives ram2 wena.
REQ-015 ram_addr  out  ADDR_W  drives ram2 addr.
REQ-016 ram_data  inout  DATA_W  ram2 bidirectional data bus.

Function
REQ-017 The controller SHALL complete a request when req_valid && req_ready at a rising edge; req_addr/req_we/req_wdata SHALL be registered on acceptance.
REQ-018 req_ready SHALL be 1 only in IDLE; one request outstanding at a time.
REQ-019 States SHALL be IDLE, WRITE, READ, RCAP, TURN (plus CLEAR under REQ-031).
REQ-020 IDLE->WRITE on accepted write; IDLE->READ on accepted read; otherwise stay.
REQ-021 WRITE (1 cycle) SHALL assert ram_ena=1, ram_wena=1, ram_addr, drive ram_data with registered wdata; ram2 commits at the next edge; next IDLE.
REQ-022 READ SHALL assert ram_ena=1, ram_wena=0, ram_data=Z; next RCAP.
REQ-023 RCAP SHALL keep READ's outputs and capture ram_data into rsp_rdata at its closing edge; rsp_valid SHALL be 1 in the following cycle; next TURN.
REQ-024 TURN (1 cycle) SHALL hold ram_ena=0, ram_data=Z as bus turnaround; next IDLE.
REQ-025 Latency: write accept->IDLE 1 cycle; read accept->rsp_valid 3 cycles; read throughput one per 4 cycles, write one per 2.
REQ-026 ram_data SHALL be driven only in WRITE (and CLEAR); Z in every other state and during reset.
REQ-027 Outside WRITE/READ/RCAP/CLEAR, ram_ena=0, ram_wena=0, ram_addr holds last value.
REQ-028 req_valid deasserted in non-IDLE states SHALL have no effect; inputs SHALL be ignored when req_ready=0.
REQ-029 Address 31 and address 0 SHALL be handled identically to all others; no wrap or auto-increment in normal operation.

Reset
REQ-030 On rst_n=0 (any state, mid-operation included): state IDLE (or CLEAR per REQ-031), req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, busy=0, ram_ena=0, ram_wena=0, ram_addr=0, ram_data=Z; an interrupted request SHALL be dropped with no response.

Configuration
REQ-031 Macro RAM2_CTRL_CLEAR_EN: when defined, after reset release the controller SHALL enter CLEAR, write 0 to addresses 0..31 one per cycle (ram_ena=1, ram_wena=1, 5-bit counter), busy=1, req_ready=0, then IDLE after 32 cycles; when undefined, reset exits directly to IDLE and RAM contents are untouched.

Structure
REQ-032 Package ram2_pkg SHALL hold ADDR_W/DATA_W defaults, the state enum typedef, and the CLEAR word count (32).
REQ-033 One sub-module, ram2_bus_drv, SHALL implement the tri-state driver (oe, dout, din) for ram_data; no other hierarchy.

Verification
REQ-034 Write 0xabcdef12 to 0x0A, then 0x12345678 to 0x15 -> ram2 words 10/21 hold those values; req_ready back high 1 cycle after each accept.
REQ-035 Read 0x0A then 0x15 -> rsp_valid pulses 3 cycles after each accept with 0xabcdef12 then 0x12345678; ram_data never driven by controller during READ/RCAP/TURN.
REQ-036 Write 0xFFFFFFFF to 0x1F, read 0x1F, write 0x00000001 to 0x00 back-to-back -> read returns 0xFFFFFFFF; no bus contention in TURN cycle.
REQ-037 Assert rst_n=0 in RCAP of a read of 0x0A -> no rsp_valid, all outputs at reset values, ram_data=Z.
REQ-038 With RAM2_CTRL_CLEAR_EN: preload 0x5A5A5A5A at 0x07, reset -> busy 32 cycles, then read 0x07 returns 0x00000000; without the macro it returns 0x5A5A5A5A.
